shift42_tx: RTL and testbench

Serializer that drives the 42-bit serial readout link consumed by the TDC readout shift receiver. It accepts a parallel word of address, read/write flag, data and trailer bit, and generates the serial clock, frame enable and serial data. Each bit is shifted out MSB-first so that the receiver's register holds the following layout after 42 rising edges: {addr[7:0], rw, data[31:0], t}. It sits on the control/readout side, opposite the receiver, and is also used as the stimulus source in link loopback tests.

---
 rtl/shift42_tx.sv | 156 +++++++++++++++
 tb/tb_shift42_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift42_tx.sv
// shift42_tx: serializer for the 42-bit readout link.
//
// The frame {addr, rw, data, t} is captured on an accepted start. It is then
// shifted out MSB-first on sda, with a divided serial clock on sclk and a
// frame enable on sen. The receiver samples sda on each rising sclk edge.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   one-cycle frame request, honoured only while busy=0
//   addr   in   [7:0]  frame address, sent first
//   rw     in   read/write flag
//   data   in   [31:0] payload
//   t      in   trailer/test bit, sent last
//   sclk   out  serial clock
//   sen    out  frame enable
//   sda    out  serial data
//   busy   out  frame in progress
//   done   out  one-cycle pulse at frame end
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | link quiet, waiting for start
// LOW   | sclk low for CLK_DIV cycles, sda holds the current bit
// HIGH  | sclk high for CLK_DIV cycles, receiver samples on entry
// TAIL  | sclk low for CLK_DIV cycles after the last bit, sen still high
// DONE  | one cycle with done=1, busy=0; a new start is accepted here
module shift42_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  addr,
    input  logic        rw,
    input  logic [31:0] data,
    input  logic        t,
    output logic        sclk,
    output logic        sen,
    output logic        sda,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        TAIL,
        DONE
    } state_t;

    localparam logic [15:0] DIV_TC   = 16'(CLK_DIV - 1);
    localparam logic [5:0]  LAST_BIT = 6'd41;

    state_t      state_q;
    logic [40:0] shreg_q;     // bits still to send after the one on sda
    logic [5:0]  bit_cnt_q;
    logic [15:0] div_cnt_q;
    logic        sclk_q;
    logic        sen_q;
    logic        sda_q;
    logic        busy_q;
    logic        done_q;

    logic        div_tc;
    logic [41:0] frame;

    assign div_tc = (div_cnt_q == DIV_TC);
    assign frame  = {addr, rw, data, t};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sen_q     <= 1'b0;
            sda_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                // busy is low in both IDLE and DONE, so start is honoured
                // directly here and ignored everywhere else.
                IDLE, DONE: begin
                    done_q    <= 1'b0;
                    sclk_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    div_cnt_q <= '0;
                    if (start) begin
                        state_q <= LOW;
                        shreg_q <= frame[40:0];
                        sda_q   <= frame[41];
                        sen_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        sda_q   <= 1'b0;
                        sen_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                LOW: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        sclk_q    <= 1'b1;
                        state_q   <= HIGH;
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                HIGH: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        sclk_q    <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= TAIL;
                        end else begin
                            // next bit appears on the same edge sclk falls
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            sda_q     <= shreg_q[40];
                            shreg_q   <= {shreg_q[39:0], 1'b0};
                            state_q   <= LOW;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                TAIL: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        sen_q     <= 1'b0;
                        sda_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sclk = sclk_q;
    assign sen  = sen_q;
    assign sda  = sda_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift42_tx.sv
// Testbench for shift42_tx. Three instances cover CLK_DIV = 1, 3 and 2.
// Stimulus pushes each expected frame into a scoreboard queue. A monitor per
// instance rebuilds the frame from sclk/sda and checks it when done pulses.
module tb_shift42_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  start;
    logic [2:0]  rw;
    logic [2:0]  t;
    logic [7:0]  addr [3];
    logic [31:0] data [3];
    logic [2:0]  sclk_w, sen_w, sda_w, busy_w, done_w;
    logic [2:0]  chk_gap;

    typedef struct {
        int          inst;
        logic [41:0] frame;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    shift42_tx #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .addr(addr[0]), .rw(rw[0]),
        .data(data[0]), .t(t[0]), .sclk(sclk_w[0]), .sen(sen_w[0]), .sda(sda_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );
    shift42_tx #(.CLK_DIV(3)) u_d3 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .addr(addr[1]), .rw(rw[1]),
        .data(data[1]), .t(t[1]), .sclk(sclk_w[1]), .sen(sen_w[1]), .sda(sda_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );
    shift42_tx #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .addr(addr[2]), .rw(rw[2]),
        .data(data[2]), .t(t[2]), .sclk(sclk_w[2]), .sen(sen_w[2]), .sda(sda_w[2]),
        .busy(busy_w[2]), .done(done_w[2])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        logic [41:0] rx;
        int          rises, busy_cnt, run_len, phase_bad, sda_bad, gap_cnt;
        logic        in_frame, run_lvl, prev_sclk, prev_sda, prev_sen, prev_done, done_seen;
        exp_t        e;

        task automatic clr();
            rx        = '0;
            rises     = 0;
            busy_cnt  = 0;
            run_len   = 0;
            phase_bad = 0;
            sda_bad   = 0;
            in_frame  = 1'b0;
        endtask

        initial begin
            clr();
            gap_cnt   = 0;
            run_lvl   = 1'b0;
            prev_sclk = 1'b0;
            prev_sda  = 1'b0;
            prev_sen  = 1'b0;
            prev_done = 1'b0;
            done_seen = 1'b0;
        end

        always @(negedge clk) begin
            if (done_seen)
                chk($sformatf("done_width[%0d]", g), 64'(done_w[g]), 64'd0);
            done_seen = 1'b0;

            if (sen_w[g] && !prev_sen) begin
                if (chk_gap[g]) begin
                    chk($sformatf("sen_gap[%0d]", g), 64'(gap_cnt), 64'd1);
                    chk($sformatf("sen_after_done[%0d]", g), 64'(prev_done), 64'd1);
                end
                gap_cnt = 0;
            end else if (!sen_w[g]) begin
                gap_cnt++;
            end

            if (done_w[g]) begin
                if (run_len != D) phase_bad++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame[%0d]: got frame 0x%0h, required no frame", g, rx);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("frame_inst[%0d]", g), 64'(e.inst), 64'(g));
                    chk($sformatf("frame_data[%0d]", g), 64'(rx), 64'(e.frame));
                    chk($sformatf("rise_count[%0d]", g), 64'(rises), 64'd42);
                    chk($sformatf("busy_cycles[%0d]", g), 64'(busy_cnt), 64'(85 * D));
                    chk($sformatf("phase_len_errs[%0d]", g), 64'(phase_bad), 64'd0);
                    chk($sformatf("sda_while_sclk_hi[%0d]", g), 64'(sda_bad), 64'd0);
                end
                done_seen = 1'b1;
                clr();
            end else if (!sen_w[g]) begin
                clr();
            end else begin
                if (busy_w[g]) busy_cnt++;
                if (!in_frame) begin
                    in_frame = 1'b1;
                    run_lvl  = sclk_w[g];
                    run_len  = 1;
                end else if (sclk_w[g] == run_lvl) begin
                    run_len++;
                end else begin
                    if (run_len != D) phase_bad++;
                    run_lvl = sclk_w[g];
                    run_len = 1;
                end
                if (sclk_w[g] && (sda_w[g] != prev_sda)) sda_bad++;
                if (sclk_w[g] && !prev_sclk) begin
                    rx = {rx[40:0], sda_w[g]};
                    rises++;
                end
            end

            prev_sclk = sclk_w[g];
            prev_sda  = sda_w[g];
            prev_sen  = sen_w[g];
            prev_done = done_w[g];
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int i, input logic [7:0] a, input logic r, input logic [31:0] d,
                        input logic tt, input logic [41:0] expf, input bit push, input bit corrupt);
        @(negedge clk);
        addr[i]  = a;
        rw[i]    = r;
        data[i]  = d;
        t[i]     = tt;
        start[i] = 1'b1;
        if (push) sb.push_back('{i, expf});
        @(negedge clk);
        start[i] = 1'b0;
        if (corrupt) begin
            addr[i] = '1;
            rw[i]   = 1'b1;
            data[i] = '1;
            t[i]    = 1'b1;
        end
        chk($sformatf("first_cycle[%0d]", i),
            64'({sclk_w[i], sen_w[i], busy_w[i], sda_w[i]}),
            64'({1'b0, 1'b1, 1'b1, a[7]}));
    endtask

    task automatic wait_done(input int i, input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done_w[i]) begin
                got = 1'b1;
                break;
            end
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int   r;
        int   cnt;
        logic prev;

        rst     = 3'b111;
        start   = '0;
        rw      = '0;
        t       = '0;
        chk_gap = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_outputs[%0d]", i),
                64'({sclk_w[i], sen_w[i], sda_w[i], busy_w[i], done_w[i]}), 64'd0);
        repeat (2) @(negedge clk);
        rst = '0;

        // CLK_DIV=1: {A5,1,DEADBEEF,0}
        send(0, 8'hA5, 1'b1, 32'hDEADBEEF, 1'b0, 42'h297_BD5B_7DDE, 1'b1, 1'b0);
        wait_done(0, "d1_done");

        // CLK_DIV=3: {55,0,AAAAAAAA,1}
        send(1, 8'h55, 1'b0, 32'hAAAAAAAA, 1'b1, 42'h155_5555_5555, 1'b1, 1'b0);
        wait_done(1, "d3_done");

        // CLK_DIV=2: start re-pulsed mid-frame with other inputs: {3C,0,12345678,1}
        send(2, 8'h3C, 1'b0, 32'h12345678, 1'b1, 42'h0F0_2468_ACF1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        addr[2]  = 8'hFF;
        rw[2]    = 1'b1;
        data[2]  = 32'h0;
        t[2]     = 1'b0;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        wait_done(2, "repulse_done");
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy_w[2]) cnt++;
        end
        chk("repulse_no_second_frame", 64'(cnt), 64'd0);

        // inputs go all-ones right after capture: {81,1,0000FFFF,0}
        send(2, 8'h81, 1'b1, 32'h0000FFFF, 1'b0, 42'h206_0001_FFFE, 1'b1, 1'b1);
        wait_done(2, "corrupt_done");

        // reset at the 20th sclk rise, frame is abandoned
        send(2, 8'h99, 1'b1, 32'h0BADF00D, 1'b0, 42'd0, 1'b0, 1'b0);
        r    = 0;
        prev = sclk_w[2];
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (sclk_w[2] && !prev) r++;
            prev = sclk_w[2];
            if (r == 20) break;
        end
        chk("rst_rise20_reached", 64'(r), 64'd20);
        rst[2] = 1'b1;
        @(negedge clk);
        chk("rst_midframe_outputs",
            64'({sclk_w[2], sen_w[2], sda_w[2], busy_w[2], done_w[2]}), 64'd0);
        rst[2] = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_w[2] || sen_w[2]) cnt++;
        end
        chk("rst_no_done_or_resume", 64'(cnt), 64'd0);
        send(2, 8'hC3, 1'b1, 32'h0F0F0F0F, 1'b1, 42'h30E_1E1E_1E1F, 1'b1, 1'b0);
        wait_done(2, "post_rst_done");

        // back-to-back with start held high: {01,0,00000001,0} then {FE,1,80000000,1}
        @(negedge clk);
        addr[2]  = 8'h01;
        rw[2]    = 1'b0;
        data[2]  = 32'h00000001;
        t[2]     = 1'b0;
        start[2] = 1'b1;
        sb.push_back('{2, 42'h004_0000_0002});
        @(negedge clk);
        addr[2]  = 8'hFE;
        rw[2]    = 1'b1;
        data[2]  = 32'h80000000;
        t[2]     = 1'b1;
        sb.push_back('{2, 42'h3FB_0000_0001});
        @(negedge clk);
        chk_gap[2] = 1'b1;
        wait_done(2, "b2b_done_a");
        @(negedge clk);
        start[2] = 1'b0;
        chk("b2b_second_sen", 64'(sen_w[2]), 64'd1);
        wait_done(2, "b2b_done_b");
        chk_gap[2] = 1'b0;

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
